// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ctrl_t control bundle, XZR register index, CTRL_BUBBLE no-op control word.
package id_ex_stage_pkg;

   // Control bundle carried down the pipe; field order fixes the 8-bit packing.
   typedef struct packed {
      logic       RegWrite;
      logic       MemRead;
      logic       MemWrite;
      logic       MemToReg;
      logic       ALUSrc;
      logic [2:0] ALUOp;
   } ctrl_t;

   // Zero register: writes are discarded, so it can never carry a dependency.
   localparam logic [4:0] XZR = 5'd31;

   // All-zero control: RegWrite=0 and MemWrite=0, so a bubble is never forwarded.
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: flags an IF/ID instruction that reads the destination of a load in ID/EX.
// Latency: purely combinational, result valid in the same cycle.
// Backpressure: none; the parent turns luh into a stall.
// Ports: idex_valid/idex_mem_read/idex_rd (instruction in ID/EX), ifid_valid/ifid_rn/ifid_rm/
//        ifid_use_rn/ifid_use_rm (instruction in IF/ID), luh (hazard flag).
module hazard_detect
   import id_ex_stage_pkg::*;
(
   input  logic       idex_valid,
   input  logic       idex_mem_read,
   input  logic [4:0] idex_rd,
   input  logic       ifid_valid,
   input  logic [4:0] ifid_rn,
   input  logic [4:0] ifid_rm,
   input  logic       ifid_use_rn,
   input  logic       ifid_use_rm,
   output logic       luh
);

   logic rn_match;
   logic rm_match;

   // Only sources the instruction actually reads can create a dependency.
   assign rn_match = ifid_use_rn & (idex_rd == ifid_rn);
   assign rm_match = ifid_use_rm & (idex_rd == ifid_rm);

   assign luh = idex_valid & idex_mem_read & (idex_rd != XZR) & ifid_valid
              & (rn_match | rm_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and downstream hold; optional stall counter
// behind macro STALL_COUNTER_EN. Latency: one cycle from ifid_* to idex_*.
// Backpressure: hold freezes the stage and raises stall; flush overrides stall and inserts a bubble.
// Ports: clk, reset (sync, active-high); ifid_* decoded instruction in; flush, hold control;
//        stall to PC/IF-ID write enables; idex_*/IDEX_* registered outputs; stall_count (macro only).
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int STALL_CNT_W = 16
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ifid_valid,
   input  logic [4:0]             ifid_Rn,
   input  logic [4:0]             ifid_Rm,
   input  logic [4:0]             ifid_Rd,
   input  logic                   ifid_useRn,
   input  logic                   ifid_useRm,
   input  ctrl_t                  ifid_ctrl,
   input  logic [63:0]            ifid_rdata1,
   input  logic [63:0]            ifid_rdata2,
   input  logic [63:0]            ifid_imm,
   input  logic                   flush,
   input  logic                   hold,
   output logic                   stall,
   output logic                   idex_valid,
   output logic [4:0]             IDEX_Rn,
   output logic [4:0]             IDEX_Rm,
   output logic [4:0]             IDEX_Rd,
   output ctrl_t                  idex_ctrl,
   output logic [63:0]            idex_rdata1,
   output logic [63:0]            idex_rdata2,
   output logic [63:0]            idex_imm
`ifdef STALL_COUNTER_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_count
`endif
);

   logic luh;

   hazard_detect u_hazard_detect (
      .idex_valid    (idex_valid),
      .idex_mem_read (idex_ctrl.MemRead),
      .idex_rd       (IDEX_Rd),
      .ifid_valid    (ifid_valid),
      .ifid_rn       (ifid_Rn),
      .ifid_rm       (ifid_Rm),
      .ifid_use_rn   (ifid_useRn),
      .ifid_use_rm   (ifid_useRm),
      .luh           (luh)
   );

   // A flush discards the IF/ID instruction anyway, so there is nothing to stall for.
   // Reset masks stall so hold is ignored while the pipe is being cleared.
   assign stall = ~reset & (luh | hold) & ~flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         idex_valid  <= 1'b0;
         idex_ctrl   <= CTRL_BUBBLE;
         IDEX_Rn     <= XZR;
         IDEX_Rm     <= XZR;
         IDEX_Rd     <= XZR;
         idex_rdata1 <= '0;
         idex_rdata2 <= '0;
         idex_imm    <= '0;
      end else if (flush) begin
         // Bubble: only valid and ctrl matter, the rest is left as-is.
         idex_valid <= 1'b0;
         idex_ctrl  <= CTRL_BUBBLE;
      end else if (hold) begin
         // Downstream busy: keep every field.
      end else if (luh) begin
         // Bubble with XZR register fields so nothing can match it next cycle;
         // MemRead=0 guarantees the stall lasts a single cycle.
         idex_valid <= 1'b0;
         idex_ctrl  <= CTRL_BUBBLE;
         IDEX_Rn    <= XZR;
         IDEX_Rm    <= XZR;
         IDEX_Rd    <= XZR;
      end else begin
         idex_valid  <= ifid_valid;
         idex_ctrl   <= ifid_valid ? ifid_ctrl : CTRL_BUBBLE;
         IDEX_Rn     <= ifid_Rn;
         IDEX_Rm     <= ifid_Rm;
         IDEX_Rd     <= ifid_Rd;
         idex_rdata1 <= ifid_rdata1;
         idex_rdata2 <= ifid_rdata2;
         idex_imm    <= ifid_imm;
      end
   end

`ifdef STALL_COUNTER_EN
   // Saturating count of stalled cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (stall && (stall_count != {STALL_CNT_W{1'b1}})) begin
         stall_count <= stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by randomized traffic, checked against a
// behavioural model of the stage. Build with STALL_COUNTER_EN to also check the counter.
// Ports of the DUT are all driven/observed here.
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

`ifdef STALL_COUNTER_EN
   localparam int CW = 8;
`else
   localparam int CW = 16;
`endif

   logic        clk;
   logic        reset;
   logic        ifid_valid;
   logic [4:0]  ifid_Rn, ifid_Rm, ifid_Rd;
   logic        ifid_useRn, ifid_useRm;
   ctrl_t       ifid_ctrl;
   logic [63:0] ifid_rdata1, ifid_rdata2, ifid_imm;
   logic        flush, hold;
   logic        stall;
   logic        idex_valid;
   logic [4:0]  IDEX_Rn, IDEX_Rm, IDEX_Rd;
   ctrl_t       idex_ctrl;
   logic [63:0] idex_rdata1, idex_rdata2, idex_imm;
`ifdef STALL_COUNTER_EN
   logic [CW-1:0] stall_count;
`endif

   int total = 0;
   int bad   = 0;

   id_ex_stage #(.STALL_CNT_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .ifid_valid  (ifid_valid),
      .ifid_Rn     (ifid_Rn),
      .ifid_Rm     (ifid_Rm),
      .ifid_Rd     (ifid_Rd),
      .ifid_useRn  (ifid_useRn),
      .ifid_useRm  (ifid_useRm),
      .ifid_ctrl   (ifid_ctrl),
      .ifid_rdata1 (ifid_rdata1),
      .ifid_rdata2 (ifid_rdata2),
      .ifid_imm    (ifid_imm),
      .flush       (flush),
      .hold        (hold),
      .stall       (stall),
      .idex_valid  (idex_valid),
      .IDEX_Rn     (IDEX_Rn),
      .IDEX_Rm     (IDEX_Rm),
      .IDEX_Rd     (IDEX_Rd),
      .idex_ctrl   (idex_ctrl),
      .idex_rdata1 (idex_rdata1),
      .idex_rdata2 (idex_rdata2),
      .idex_imm    (idex_imm)
`ifdef STALL_COUNTER_EN
      ,
      .stall_count (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected content of the ID/EX stage. Fields the design may leave arbitrary
   // (after a flush or a load-use bubble) are tracked as unknown and not compared.
   bit          m_valid;
   ctrl_t       m_ctrl;
   logic [4:0]  m_rn, m_rm, m_rd;
   logic [63:0] m_r1, m_r2, m_imm;
   bit          m_regs_known, m_data_known;
   longint      m_cnt;
   longint      cnt_max = (longint'(1) << CW) - 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A valid load in ID/EX writing a real register that the valid IF/ID instruction reads.
   function automatic bit model_luh();
      bit reads_it;
      if (!(m_valid && m_ctrl.MemRead && ifid_valid) || m_rd == 5'd31) return 1'b0;
      reads_it = (ifid_useRn && ifid_Rn == m_rd) || (ifid_useRm && ifid_Rm == m_rd);
      return reads_it;
   endfunction

   // Called just after a falling edge with inputs already applied; returns at the next falling edge.
   task automatic tick();
      bit luh, exp_stall;
      #1;
      luh       = model_luh();
      exp_stall = !reset && (luh || hold) && !flush;
      chk("stall", stall, exp_stall);
      if (reset) begin
         m_valid = 0; m_ctrl = '0;
         m_rn = 31; m_rm = 31; m_rd = 31;
         m_r1 = 0; m_r2 = 0; m_imm = 0;
         m_regs_known = 1; m_data_known = 1; m_cnt = 0;
      end else begin
         if (exp_stall && m_cnt < cnt_max) m_cnt = m_cnt + 1;
         if (flush) begin
            m_valid = 0; m_ctrl = '0; m_regs_known = 0; m_data_known = 0;
         end else if (hold) begin
            // frozen
         end else if (luh) begin
            m_valid = 0; m_ctrl = '0;
            m_rn = 31; m_rm = 31; m_rd = 31;
            m_regs_known = 1; m_data_known = 0;
         end else begin
            m_valid = ifid_valid;
            m_ctrl  = ifid_valid ? ifid_ctrl : '0;
            m_rn = ifid_Rn; m_rm = ifid_Rm; m_rd = ifid_Rd;
            m_r1 = ifid_rdata1; m_r2 = ifid_rdata2; m_imm = ifid_imm;
            m_regs_known = 1; m_data_known = 1;
         end
      end
      @(posedge clk);
      #1;
      chk("idex_valid", idex_valid, m_valid);
      chk("idex_ctrl", idex_ctrl, m_ctrl);
      if (m_regs_known) begin
         chk("IDEX_Rn", IDEX_Rn, m_rn);
         chk("IDEX_Rm", IDEX_Rm, m_rm);
         chk("IDEX_Rd", IDEX_Rd, m_rd);
      end
      if (m_data_known) begin
         chk("idex_rdata1", idex_rdata1, m_r1);
         chk("idex_rdata2", idex_rdata2, m_r2);
         chk("idex_imm", idex_imm, m_imm);
      end
`ifdef STALL_COUNTER_EN
      chk("stall_count", stall_count, m_cnt);
`endif
      @(negedge clk);
   endtask

   task automatic set_ifid(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                           input logic [4:0] rd, input logic urn, input logic urm,
                           input ctrl_t c);
      ifid_valid = v; ifid_Rn = rn; ifid_Rm = rm; ifid_Rd = rd;
      ifid_useRn = urn; ifid_useRm = urm; ifid_ctrl = c;
      ifid_rdata1 = {$urandom, $urandom};
      ifid_rdata2 = {$urandom, $urandom};
      ifid_imm    = {$urandom, $urandom};
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 3))
         0:       return 5'd2;
         1:       return 5'd5;
         2:       return 5'd31;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   ctrl_t c_ldur, c_add;

   initial begin
      c_ldur = '{RegWrite: 1'b1, MemRead: 1'b1, MemWrite: 1'b0, MemToReg: 1'b1,
                 ALUSrc: 1'b1, ALUOp: 3'd0};
      c_add  = '{RegWrite: 1'b1, MemRead: 1'b0, MemWrite: 1'b0, MemToReg: 1'b0,
                 ALUSrc: 1'b0, ALUOp: 3'd2};
      reset = 1'b1; flush = 1'b0; hold = 1'b0;
      set_ifid(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, '0);
      @(negedge clk);
      // Reset, with hold asserted on the second cycle (must not stall).
      tick();
      hold = 1'b1;
      tick();
      hold = 1'b0; reset = 1'b0;

      // Load-use: LDUR X2 then ADD reading X2 -> one-cycle bubble, then ADD loads.
      set_ifid(1'b1, 5'd3, 5'd0, 5'd2, 1'b1, 1'b0, c_ldur);
      tick();
      set_ifid(1'b1, 5'd2, 5'd4, 5'd6, 1'b1, 1'b1, c_add);
      tick();
      chk("bubble_regwrite", idex_ctrl.RegWrite, 1'b0);
      chk("bubble_memwrite", idex_ctrl.MemWrite, 1'b0);
      tick();
      chk("add_loaded_rd", IDEX_Rd, 5'd6);

      // Load to XZR never creates a hazard.
      set_ifid(1'b1, 5'd3, 5'd0, 5'd31, 1'b1, 1'b0, c_ldur);
      tick();
      set_ifid(1'b1, 5'd31, 5'd4, 5'd7, 1'b1, 1'b0, c_add);
      tick();

      // Matching Rm that is not read is not a hazard.
      set_ifid(1'b1, 5'd3, 5'd0, 5'd5, 1'b1, 1'b0, c_ldur);
      tick();
      set_ifid(1'b1, 5'd1, 5'd5, 5'd8, 1'b1, 1'b0, c_add);
      tick();

      // Hold for three cycles with the ADD in ID/EX.
      set_ifid(1'b1, 5'd9, 5'd10, 5'd11, 1'b1, 1'b1, c_add);
      hold = 1'b1;
      repeat (3) tick();
      hold = 1'b0;
      tick();

      // Flush beats a simultaneous load-use hazard and hold.
      set_ifid(1'b1, 5'd3, 5'd0, 5'd7, 1'b1, 1'b0, c_ldur);
      tick();
      set_ifid(1'b1, 5'd7, 5'd0, 5'd12, 1'b1, 1'b0, c_add);
      hold = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;

      // Reset during hold wins, then normal load resumes.
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; hold = 1'b0;
      tick();

`ifdef STALL_COUNTER_EN
      // Drive the counter into saturation and keep stalling.
      hold = 1'b1;
      repeat (cnt_max + 5) tick();
      hold = 1'b0;
      tick();
`endif

      // Randomized traffic biased towards hazards.
      for (int i = 0; i < 400; i++) begin
         ctrl_t c;
         c = ctrl_t'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 0) c.MemRead = 1'b1;
         set_ifid($urandom_range(0, 3) != 0, pick_reg(), pick_reg(), pick_reg(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c);
         reset = ($urandom_range(0, 39) == 0);
         flush = ($urandom_range(0, 7) == 0);
         hold  = ($urandom_range(0, 5) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of the stall-cycle counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports ifid_valid  input  1; ifid_Rn, ifid_Rm, ifid_Rd  input  5 each; ifid_useRn, ifid_useRm  input  1 each (source actually read).
REQ-005 SHALL have ports ifid_ctrl  input  ctrl_t (8): RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp[2:0]; ifid_rdata1, ifid_rdata2, ifid_imm  input  64 each.
REQ-006 SHALL have ports flush  input  1 (taken branch); hold  input  1 (downstream memory busy).
REQ-007 SHALL have port stall  output  1  deasserts PC and IF/ID write enable.
REQ-008 SHALL have ports idex_valid  output  1; IDEX_Rn, IDEX_Rm, IDEX_Rd  output  5 each; idex_ctrl  output  ctrl_t; idex_rdata1, idex_rdata2, idex_imm  output  64 each.
REQ-009 SHALL have port stall_count  output  STALL_CNT_W, present only under STALL_COUNTER_EN.

Function
REQ-010 SHALL compute load-use hazard luh = idex_valid & idex_ctrl.MemRead & IDEX_Rd!=31 & ifid_valid & ((ifid_useRn & IDEX_Rd==ifid_Rn) | (ifid_useRm & IDEX_Rd==ifid_Rm)), combinationally.
REQ-011 SHALL drive stall = (luh | hold) & ~flush, combinationally in the same cycle.
REQ-012 SHALL update registers each edge with priority reset > flush > hold > luh > normal load.
REQ-013 flush SHALL clear idex_valid and idex_ctrl to zero (bubble); data/register fields don't-care.
REQ-014 hold SHALL retain all ID/EX registers unchanged for every held cycle.
REQ-015 luh (no flush, no hold) SHALL load a bubble: idex_valid=0, idex_ctrl=0, IDEX_Rn/Rm/Rd=31.
REQ-016 Normal load SHALL capture all ifid_* fields with one-cycle latency; ifid_valid=0 loads ctrl as zero.
REQ-017 A load-use stall SHALL last exactly one cycle absent hold, since the inserted bubble has MemRead=0.
REQ-018 Register 31 (XZR) SHALL never trigger a hazard as IDEX_Rd.
REQ-019 Bubble ctrl fields SHALL guarantee RegWrite=0 and MemWrite=0 so the downstream forwarding unit never forwards from a bubble.

Reset
REQ-020 reset SHALL set idex_valid=0, idex_ctrl=0, IDEX_Rn/Rm/Rd=31, data registers=0, stall_count=0.
REQ-021 stall SHALL be 0 during reset cycles since idex_valid=0 and hold is ignored while reset=1.
REQ-022 reset asserted mid-hold or mid-stall SHALL win that edge; operation resumes with normal load on the first edge after deassertion.

Configuration
REQ-023 Macro STALL_COUNTER_EN SHALL compile in stall_count, incremented by 1 each edge with stall=1, saturating at all-ones.
REQ-024 Without STALL_COUNTER_EN the port and counter SHALL be absent; other behaviour identical.

Structure
REQ-025 Shared package SHALL hold ctrl_t (packed struct, 8 bits), constant XZR=5'd31 and constant CTRL_BUBBLE='0.
REQ-026 One sub-module hazard_detect SHALL be instantiated, purely combinational, computing luh from REQ-010.

Verification
REQ-027 LDUR X2 in ID/EX (MemRead=1, Rd=2), ADD reading Rn=2 in IF/ID -> stall=1 one cycle, next idex_valid=0, ctrl=0; following cycle ADD loads, stall=0.
REQ-028 LDUR Rd=31, IF/ID Rn=31 useRn=1 -> stall=0, normal load.
REQ-029 LDUR Rd=5, IF/ID Rm=5 useRm=0 -> stall=0.
REQ-030 hold=1 for 3 cycles with ADD X1 in ID/EX -> outputs unchanged 3 cycles, stall=1; stall_count +3 with macro.
REQ-031 flush=1 simultaneous with luh=1 and hold=1 -> stall=0, next idex_valid=0, idex_ctrl=0.
REQ-032 reset=1 during hold -> next edge idex_valid=0, IDEX_Rd=31, stall_count=0; 8-bit counter build at 255 with stall=1 stays 255.
